// File: rtl/box_plot_if.sv
// Command/strobe bundle between the box-plot controller and its host.
// The host drives master; the controller uses slave.
interface box_plot_if #(
  parameter int OFS_BITS = 2
);
  logic                go;
  logic                draw;
  logic                clear;
  logic                ld_x;
  logic                ld_y;
  logic                ld_c;
  logic [OFS_BITS-1:0] offset_x;
  logic [OFS_BITS-1:0] offset_y;
  logic [7:0]          clr_x;
  logic [6:0]          clr_y;
  logic                clr_active;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output go, draw, clear,
    input  ld_x, ld_y, ld_c, offset_x, offset_y, clr_x, clr_y,
           clr_active, plot, busy, done
  );

  modport slave (
    input  go, draw, clear,
    output ld_x, ld_y, ld_c, offset_x, offset_y, clr_x, clr_y,
           clr_active, plot, busy, done
  );
endinterface

// File: rtl/box_plot_controller.sv
// Moore FSM sequencing load-X, load-Y/colour, box pixel sweep and full-screen clear.
// Optional: define AUTO_CLEAR_ON_RESET_EN to blank the screen once after reset.
module box_plot_controller #(
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4,
  parameter int OFS_BITS = 2,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       reset,
  box_plot_if.slave  bus
);

  typedef enum logic [2:0] {
    WAIT_X    = 3'd0,
    LOAD_X    = 3'd1,
    WAIT_Y    = 3'd2,
    LOAD_Y    = 3'd3,
    WAIT_DRAW = 3'd4,
    DRAW      = 3'd5,
    DONE      = 3'd6,
    CLEAR     = 3'd7
  } state_t;

  localparam logic [OFS_BITS-1:0] LAST_OX = OFS_BITS'(BOX_W - 1);
  localparam logic [OFS_BITS-1:0] LAST_OY = OFS_BITS'(BOX_H - 1);
  localparam logic [7:0]          LAST_CX = 8'(SCREEN_W - 1);
  localparam logic [6:0]          LAST_CY = 7'(SCREEN_H - 1);

`ifdef AUTO_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = WAIT_X;
`endif

  state_t              state;
  state_t              next_state;
  logic [OFS_BITS-1:0] ofs_x;
  logic [OFS_BITS-1:0] ofs_y;
  logic [7:0]          cx;
  logic [6:0]          cy;
  logic                box_last;
  logic                clr_last;

  logic ld_x, ld_y, ld_c, clr_active, plot, busy, done;

  assign box_last = (ofs_x == LAST_OX) && (ofs_y == LAST_OY);
  assign clr_last = (cx == LAST_CX) && (cy == LAST_CY);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= RESET_STATE;
    else       state <= next_state;
  end

  // NOTE: next_state defaults to state before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_X: begin
        if (bus.clear)   next_state = CLEAR;
        else if (bus.go) next_state = LOAD_X;
      end
      LOAD_X:    if (!bus.go) next_state = WAIT_Y;
      WAIT_Y: begin
        if (bus.clear)   next_state = CLEAR;
        else if (bus.go) next_state = LOAD_Y;
      end
      LOAD_Y:    if (!bus.go) next_state = WAIT_DRAW;
      WAIT_DRAW: begin
        if (bus.clear)      next_state = CLEAR;
        else if (bus.draw)  next_state = DRAW;
        else if (bus.go)    next_state = LOAD_X;
      end
      DRAW:      if (box_last) next_state = DONE;
      CLEAR:     if (clr_last) next_state = DONE;
      DONE:      next_state = WAIT_X;
      default:   next_state = WAIT_X;
    endcase
  end

  // Sweep counters run only in their own state and sit at zero everywhere else,
  // so entering DRAW/CLEAR always starts from pixel (0,0).
  always_ff @(posedge clock) begin
    if (reset || state != DRAW) begin
      ofs_x <= '0;
      ofs_y <= '0;
    end else if (ofs_x == LAST_OX) begin
      ofs_x <= '0;
      ofs_y <= (ofs_y == LAST_OY) ? '0 : ofs_y + 1'b1;
    end else begin
      ofs_x <= ofs_x + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || state != CLEAR) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == LAST_CX) begin
      cx <= '0;
      cy <= (cy == LAST_CY) ? '0 : cy + 1'b1;
    end else begin
      cx <= cx + 1'b1;
    end
  end

  always_comb begin
    ld_x       = 1'b0;
    ld_y       = 1'b0;
    ld_c       = 1'b0;
    clr_active = 1'b0;
    plot       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      LOAD_X: ld_x = 1'b1;
      LOAD_Y: begin
        ld_y = 1'b1;
        ld_c = 1'b1;
      end
      DRAW: begin
        plot = 1'b1;
        busy = 1'b1;
      end
      CLEAR: begin
        plot       = 1'b1;
        busy       = 1'b1;
        clr_active = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.ld_x       = ld_x;
  assign bus.ld_y       = ld_y;
  assign bus.ld_c       = ld_c;
  assign bus.clr_active = clr_active;
  assign bus.plot       = plot;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.offset_x   = ofs_x;
  assign bus.offset_y   = ofs_y;
  assign bus.clr_x      = cx;
  assign bus.clr_y      = cy;

endmodule

// File: tb/tb_box_plot_controller.sv
// Self-checking bench: a 4x4 and a 2x3 controller share stimulus and are
// compared against pixel lists and step counts derived from the box/screen sizes.
module tb_box_plot_controller;

  localparam int SW = 160;
  localparam int SH = 120;

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_LDX  = 7'b0000100;
  localparam logic [6:0] F_DRAW = 7'b1100000;
  localparam logic [6:0] F_CLR  = 7'b1101000;
  localparam logic [6:0] F_DONE = 7'b0010000;

  typedef logic [25:0] obs_t;
  typedef struct { int x; int y; } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic go    = 1'b0;
  logic draw  = 1'b0;
  logic clear = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  box_plot_if #(.OFS_BITS(2)) bus_a ();
  box_plot_if #(.OFS_BITS(2)) bus_b ();

  assign bus_a.go    = go;
  assign bus_a.draw  = draw;
  assign bus_a.clear = clear;
  assign bus_b.go    = go;
  assign bus_b.draw  = draw;
  assign bus_b.clear = clear;

  box_plot_controller #(.BOX_W(4), .BOX_H(4), .OFS_BITS(2), .SCREEN_W(SW), .SCREEN_H(SH))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));

  box_plot_controller #(.BOX_W(2), .BOX_H(3), .OFS_BITS(2), .SCREEN_W(SW), .SCREEN_H(SH))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  // {plot,busy,done,clr_active,ld_x,ld_y,ld_c, offset_x, offset_y, clr_x, clr_y}
  function automatic obs_t pack(logic [6:0] f, int ox, int oy, int cx, int cy);
    return {f, 2'(ox), 2'(oy), 8'(cx), 7'(cy)};
  endfunction

  function automatic obs_t obs_a();
    return {bus_a.plot, bus_a.busy, bus_a.done, bus_a.clr_active, bus_a.ld_x, bus_a.ld_y,
            bus_a.ld_c, bus_a.offset_x, bus_a.offset_y, bus_a.clr_x, bus_a.clr_y};
  endfunction

  function automatic obs_t obs_b();
    return {bus_b.plot, bus_b.busy, bus_b.done, bus_b.clr_active, bus_b.ld_x, bus_b.ld_y,
            bus_b.ld_c, bus_b.offset_x, bus_b.offset_y, bus_b.clr_x, bus_b.clr_y};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Current sample must be the first clear pixel; ends back in WAIT_X (or in a
  // restarted CLEAR when clear is held high).
  task automatic run_clear_sweep(input string name, input bit hold_clear);
    int   bad = 0;
    obs_t first_act = '0;
    obs_t first_exp = '0;
    obs_t ex;
    for (int y = 0; y < SH; y++) begin
      for (int x = 0; x < SW; x++) begin
        ex = pack(F_CLR, 0, 0, x, y);
        if (obs_a() !== ex || obs_b() !== ex) begin
          if (bad == 0) begin
            first_exp = ex;
            first_act = (obs_a() !== ex) ? obs_a() : obs_b();
          end
          bad++;
        end
        go   = 1'($urandom_range(0, 1));
        draw = 1'($urandom_range(0, 1));
        if (x == SW - 1 && y == SH - 1) begin
          go    = 1'b0;
          draw  = 1'b0;
          clear = hold_clear;
        end else begin
          clear = hold_clear ? 1'b1 : 1'($urandom_range(0, 1));
        end
        cyc();
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_sweep: %0d bad cycles, first got %h want %h", name, bad, first_act, first_exp);
    end
    checks++;
    if (obs_a() !== pack(F_DONE, 0, 0, 0, 0) || obs_b() !== pack(F_DONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL %s_done: got a=%h b=%h want %h", name, obs_a(), obs_b(), pack(F_DONE, 0, 0, 0, 0));
    end
    cyc();
    checks++;
    if (obs_a() !== pack(F_NONE, 0, 0, 0, 0) || obs_b() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL %s_after_done: got a=%h b=%h want 0", name, obs_a(), obs_b());
    end
    if (hold_clear) begin
      cyc();
      checks++;
      if (obs_a() !== pack(F_CLR, 0, 0, 0, 0) || obs_b() !== pack(F_CLR, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL %s_restart: got a=%h b=%h want %h", name, obs_a(), obs_b(), pack(F_CLR, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic reach_wait_draw();
    go = 1'b1;
    repeat ($urandom_range(1, 3)) cyc();
    go = 1'b0;
    repeat ($urandom_range(1, 3)) cyc();
    go = 1'b1;
    repeat ($urandom_range(1, 3)) cyc();
    go = 1'b0;
    repeat ($urandom_range(1, 3)) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go = 1'b0; draw = 1'b0; clear = 1'b0;
    cyc();
    cyc();
`ifdef AUTO_CLEAR_ON_RESET_EN
    checks++;
    if (obs_a() !== pack(F_CLR, 0, 0, 0, 0) || obs_b() !== pack(F_CLR, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_state: got a=%h b=%h want %h", obs_a(), obs_b(), pack(F_CLR, 0, 0, 0, 0));
    end
    reset = 1'b0;
    run_clear_sweep("auto_clear", 1'b0);
`else
    checks++;
    if (obs_a() !== pack(F_NONE, 0, 0, 0, 0) || obs_b() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_state: got a=%h b=%h want 0", obs_a(), obs_b());
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (obs_a() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_release_idle: got %h want 0", obs_a());
    end
`endif
  endtask

  task automatic test_box_sweep();
    int   n, m;
    int   cnt_xa, cnt_xb, cnt_y, cnt_c, plots_a, plots_b;
    pix_t qa[$];
    pix_t qb[$];
    obs_t ea, eb;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) qa.push_back('{x: x, y: y});
    for (int y = 0; y < 3; y++) for (int x = 0; x < 2; x++) qb.push_back('{x: x, y: y});

    n = $urandom_range(1, 4);
    cnt_xa = 0; cnt_xb = 0;
    go = 1'b1;
    for (int i = 0; i < n + 3; i++) begin
      if (i == n) go = 1'b0;
      cyc();
      cnt_xa += int'(bus_a.ld_x);
      cnt_xb += int'(bus_b.ld_x);
    end
    checks++;
    if (cnt_xa !== n || cnt_xb !== n) begin
      errors++;
      $display("FAIL ld_x_cycles: got a=%0d b=%0d want %0d", cnt_xa, cnt_xb, n);
    end

    m = $urandom_range(1, 4);
    cnt_y = 0; cnt_c = 0;
    go = 1'b1;
    for (int i = 0; i < m + 3; i++) begin
      if (i == m) go = 1'b0;
      cyc();
      cnt_y += int'(bus_a.ld_y);
      cnt_c += int'(bus_a.ld_c);
    end
    checks++;
    if (cnt_y !== m || cnt_c !== m) begin
      errors++;
      $display("FAIL ld_yc_cycles: got y=%0d c=%0d want %0d", cnt_y, cnt_c, m);
    end

    checks++;
    if (obs_a() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL wait_draw_idle: got %h want 0", obs_a());
    end

    // draw stays high through DONE and afterwards: no second sweep may start.
    draw = 1'b1;
    plots_a = 0; plots_b = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i < 16)       ea = pack(F_DRAW, qa[i].x, qa[i].y, 0, 0);
      else if (i == 16) ea = pack(F_DONE, 0, 0, 0, 0);
      else              ea = pack(F_NONE, 0, 0, 0, 0);
      if (i < 6)        eb = pack(F_DRAW, qb[i].x, qb[i].y, 0, 0);
      else if (i == 6)  eb = pack(F_DONE, 0, 0, 0, 0);
      else              eb = pack(F_NONE, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== ea) begin
        errors++;
        $display("FAIL box4x4_cycle%0d: got %h want %h", i, obs_a(), ea);
      end
      checks++;
      if (obs_b() !== eb) begin
        errors++;
        $display("FAIL box2x3_cycle%0d: got %h want %h", i, obs_b(), eb);
      end
      plots_a += int'(bus_a.plot);
      plots_b += int'(bus_b.plot);
    end
    draw = 1'b0;
    checks++;
    if (plots_a !== 16 || plots_b !== 6) begin
      errors++;
      $display("FAIL held_draw_plots: got a=%0d b=%0d want 16/6", plots_a, plots_b);
    end
  endtask

  task automatic test_reset_mid_draw();
    reach_wait_draw();
    draw = 1'b1;
    cyc();
    repeat (7) cyc();
    checks++;
    if (obs_a() !== pack(F_DRAW, 3, 1, 0, 0) || obs_b() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL pixel7: got a=%h b=%h want a=%h b=0", obs_a(), obs_b(), pack(F_DRAW, 3, 1, 0, 0));
    end
    reset = 1'b1;
    draw  = 1'b0;
    cyc();
    reset = 1'b0;
`ifdef AUTO_CLEAR_ON_RESET_EN
    checks++;
    if (obs_a() !== pack(F_CLR, 0, 0, 0, 0) || obs_b() !== pack(F_CLR, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_draw_reset: got a=%h b=%h want %h", obs_a(), obs_b(), pack(F_CLR, 0, 0, 0, 0));
    end
    run_clear_sweep("mid_draw_reset", 1'b0);
`else
    checks++;
    if (obs_a() !== pack(F_NONE, 0, 0, 0, 0) || obs_b() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_draw_reset: got a=%h b=%h want 0", obs_a(), obs_b());
    end
    cyc();
    checks++;
    if (obs_a() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_draw_reset_idle: got %h want 0", obs_a());
    end
`endif
  endtask

  task automatic test_reload();
    reach_wait_draw();
    go = 1'b1;
    cyc();
    checks++;
    if (obs_a() !== pack(F_LDX, 0, 0, 0, 0) || obs_b() !== pack(F_LDX, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reload_ld_x: got a=%h b=%h want %h", obs_a(), obs_b(), pack(F_LDX, 0, 0, 0, 0));
    end
    go = 1'b0; cyc();
    go = 1'b1; cyc(); cyc();
    go = 1'b0; cyc();
    checks++;
    if (obs_a() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reload_back_to_wait_draw: got %h want 0", obs_a());
    end
  endtask

  // Entered from WAIT_DRAW: clear beats draw and go; clear then stays held.
  task automatic test_priority();
    clear = 1'b1; draw = 1'b1; go = 1'b1;
    cyc();
    run_clear_sweep("priority", 1'b1);
  endtask

  task automatic test_reset_abort_clear();
    clear = 1'b0;
    repeat (5) cyc();
    checks++;
    if (obs_a() !== pack(F_CLR, 0, 0, 5, 0)) begin
      errors++;
      $display("FAIL clear_progress: got %h want %h", obs_a(), pack(F_CLR, 0, 0, 5, 0));
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
`ifdef AUTO_CLEAR_ON_RESET_EN
    if (obs_a() !== pack(F_CLR, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL clear_abort_reset: got %h want %h", obs_a(), pack(F_CLR, 0, 0, 0, 0));
    end
`else
    if (obs_a() !== pack(F_NONE, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL clear_abort_reset: got %h want 0", obs_a());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_box_sweep();
    test_reset_mid_draw();
    test_reload();
    test_priority();
    test_reset_abort_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
